// File: rtl/graduation_list_mw.sv
// In-order retirement buffer: multi-lane dispatch, multi-port writeback, in-order multi-lane commit,
// partial/full flush and occupancy reporting. Head/tail carry a wrap bit to tell full from empty.
module graduation_list_mw #(
  parameter int ENTRIES    = 32,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 4,
  parameter int PAYLOAD_W  = 96,
  parameter int WB_W       = 128,
  parameter int IDX_W      = $clog2(ENTRIES)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [DISPATCH_W-1:0]           disp_valid_i,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload_i,
  output logic                            disp_ready_o,
  output logic [IDX_W-1:0]                assigned_idx_o,
  input  logic [WB_PORTS-1:0]             wb_en_i,
  input  logic [WB_PORTS*IDX_W-1:0]       wb_idx_i,
  input  logic [WB_PORTS-1:0]             wb_exc_i,
  input  logic [WB_PORTS*WB_W-1:0]        wb_data_i,
  output logic [COMMIT_W-1:0]             commit_valid_o,
  input  logic [COMMIT_W-1:0]             commit_ack_i,
  output logic [COMMIT_W*IDX_W-1:0]       commit_idx_o,
  output logic [COMMIT_W*PAYLOAD_W-1:0]   commit_payload_o,
  output logic [COMMIT_W-1:0]             commit_exc_o,
  output logic [COMMIT_W*WB_W-1:0]        commit_data_o,
  input  logic                            flush_i,
  input  logic [IDX_W-1:0]                flush_idx_i,
  input  logic                            flush_all_i,
  output logic [IDX_W:0]                  count_o,
  output logic                            full_o,
  output logic                            empty_o
);

  localparam logic [IDX_W:0] PTR_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] DEPTH_P   = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W:0] DISP_W_P  = (IDX_W+1)'(DISPATCH_W);

  logic [IDX_W:0]       head_q, head_d, tail_q, tail_d;
  logic [ENTRIES-1:0]   alloc_q, alloc_d, done_q, done_d, exc_q, exc_d;
  logic [PAYLOAD_W-1:0] payload_q [ENTRIES];
  logic [WB_W-1:0]      data_q [ENTRIES];

  logic [IDX_W:0]       count;
  logic [IDX_W:0]       retire_cnt;
  logic                 retire_run;
  logic                 lane_chain;
  logic [IDX_W-1:0]     lane_idx;
  logic                 disp_fire;
  logic [IDX_W:0]       disp_pos;
  logic [DISPATCH_W-1:0] disp_we;
  logic [IDX_W-1:0]     disp_slot [DISPATCH_W];
  logic [WB_PORTS-1:0]  wb_we;
  logic [IDX_W-1:0]     wb_slot [WB_PORTS];
  logic [IDX_W-1:0]     flush_dist;
  logic [IDX_W-1:0]     entry_off;
  logic [IDX_W-1:0]     ridx;

  assign count          = tail_q - head_q;
  assign count_o        = count;
  assign empty_o        = (head_q == tail_q);
  assign full_o         = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign assigned_idx_o = tail_q[IDX_W-1:0];

  // Handshake: a dispatch is taken on an edge where disp_ready_o=1 and no flush is active; a commit
  // lane retires on an edge where commit_valid_o[k] & commit_ack_i[k] holds for lanes 0..k.
  assign disp_ready_o = (DEPTH_P - count) >= DISP_W_P;
  assign disp_fire    = disp_ready_o && !flush_i && !flush_all_i;

  // Commit lanes: an exception entry only ever leaves on lane 0 and blocks younger lanes.
  always_comb begin
    commit_valid_o   = '0;
    commit_idx_o     = '0;
    commit_payload_o = '0;
    commit_exc_o     = '0;
    commit_data_o    = '0;
    lane_chain       = 1'b1;
    lane_idx         = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      lane_idx = head_q[IDX_W-1:0] + IDX_W'(k);
      commit_idx_o[k*IDX_W +: IDX_W]             = lane_idx;
      commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[lane_idx];
      commit_data_o[k*WB_W +: WB_W]              = data_q[lane_idx];
      commit_exc_o[k]                            = exc_q[lane_idx];
      if (lane_chain && alloc_q[lane_idx] && done_q[lane_idx] && (k == 0 || !exc_q[lane_idx])) begin
        commit_valid_o[k] = 1'b1;
        if (exc_q[lane_idx]) lane_chain = 1'b0;
      end else begin
        lane_chain = 1'b0;
      end
    end
  end

  always_comb begin
    retire_cnt = '0;
    retire_run = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (retire_run && commit_valid_o[k] && commit_ack_i[k]) retire_cnt = retire_cnt + PTR_ONE;
      else retire_run = 1'b0;
    end
  end

  // Dispatch slots: valid lanes are packed densely starting at the tail.
  always_comb begin
    disp_pos = '0;
    disp_we  = '0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      disp_slot[l] = tail_q[IDX_W-1:0] + disp_pos[IDX_W-1:0];
      if (disp_valid_i[l] && disp_fire) begin
        disp_we[l] = 1'b1;
        disp_pos   = disp_pos + PTR_ONE;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_slot[p] = wb_idx_i[p*IDX_W +: IDX_W];
      wb_we[p]   = wb_en_i[p] && alloc_q[wb_slot[p]] && !flush_all_i;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    alloc_d    = alloc_q;
    done_d     = done_q;
    exc_d      = exc_q;
    flush_dist = flush_idx_i - head_q[IDX_W-1:0];
    entry_off  = '0;
    ridx       = '0;
    // Later ports overwrite earlier ones, so the highest port wins on a shared index.
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_we[p]) begin
        done_d[wb_slot[p]] = 1'b1;
        exc_d[wb_slot[p]]  = wb_exc_i[p];
      end
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      if ((IDX_W+1)'(k) < retire_cnt) begin
        ridx          = head_q[IDX_W-1:0] + IDX_W'(k);
        alloc_d[ridx] = 1'b0;
        done_d[ridx]  = 1'b0;
      end
    end
    head_d = head_q + retire_cnt;
    if (flush_all_i) begin
      head_d  = '0;
      tail_d  = '0;
      alloc_d = '0;
      done_d  = '0;
    end else if (flush_i) begin
      // Squash by age: offsets are measured from the pre-retire head, so survivors are unaffected.
      tail_d = head_q + {1'b0, flush_dist} + PTR_ONE;
      for (int i = 0; i < ENTRIES; i++) begin
        entry_off = IDX_W'(i) - head_q[IDX_W-1:0];
        if (entry_off > flush_dist && {1'b0, entry_off} < count) begin
          alloc_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
    end else begin
      for (int l = 0; l < DISPATCH_W; l++) begin
        if (disp_we[l]) begin
          alloc_d[disp_slot[l]] = 1'b1;
          done_d[disp_slot[l]]  = 1'b0;
          exc_d[disp_slot[l]]   = 1'b0;
        end
      end
      tail_d = tail_q + disp_pos;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
    end
  end

  // Storage arrays carry no reset; they are only observed behind alloc/done.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < DISPATCH_W; l++) begin
      if (disp_we[l]) payload_q[disp_slot[l]] <= disp_payload_i[l*PAYLOAD_W +: PAYLOAD_W];
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_we[p]) data_q[wb_slot[p]] <= wb_data_i[p*WB_W +: WB_W];
    end
  end

endmodule

// File: tb/tb_graduation_list_mw.sv
// Bench for graduation_list_mw: directed scenarios plus random traffic, checked against an
// in-order queue model of the buffer through a status queue and a retirement scoreboard.
module tb_graduation_list_mw;
  localparam int E  = 32;
  localparam int DW = 2;
  localparam int CW = 2;
  localparam int WP = 4;
  localparam int PW = 96;
  localparam int WW = 128;
  localparam int IW = 5;
  localparam int EW = IW + 1 + PW + WW;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [DW-1:0]     disp_valid_i;
  logic [DW*PW-1:0]  disp_payload_i;
  logic              disp_ready_o;
  logic [IW-1:0]     assigned_idx_o;
  logic [WP-1:0]     wb_en_i;
  logic [WP*IW-1:0]  wb_idx_i;
  logic [WP-1:0]     wb_exc_i;
  logic [WP*WW-1:0]  wb_data_i;
  logic [CW-1:0]     commit_valid_o;
  logic [CW-1:0]     commit_ack_i;
  logic [CW*IW-1:0]  commit_idx_o;
  logic [CW*PW-1:0]  commit_payload_o;
  logic [CW-1:0]     commit_exc_o;
  logic [CW*WW-1:0]  commit_data_o;
  logic              flush_i;
  logic [IW-1:0]     flush_idx_i;
  logic              flush_all_i;
  logic [IW:0]       count_o;
  logic              full_o;
  logic              empty_o;

  graduation_list_mw dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .disp_valid_i(disp_valid_i), .disp_payload_i(disp_payload_i),
    .disp_ready_o(disp_ready_o), .assigned_idx_o(assigned_idx_o),
    .wb_en_i(wb_en_i), .wb_idx_i(wb_idx_i), .wb_exc_i(wb_exc_i), .wb_data_i(wb_data_i),
    .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i), .commit_idx_o(commit_idx_o),
    .commit_payload_o(commit_payload_o), .commit_exc_o(commit_exc_o), .commit_data_o(commit_data_o),
    .flush_i(flush_i), .flush_idx_i(flush_idx_i), .flush_all_i(flush_all_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IW-1:0] idx;
    logic [PW-1:0] payload;
    bit            done;
    bit            exc;
    logic [WW-1:0] data;
  } ent_t;

  ent_t           rob_q[$];
  int             m_head = 0;
  logic [EW-1:0]  exp_q[$];
  logic [15:0]    stat_q[$];
  int             checks = 0;
  int             errors = 0;
  bit             mon_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [WW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Lane k may commit when entries 0..k of the program-order queue are complete; an exception
  // entry may only be the oldest presented entry and nothing younger is presented beside it.
  function automatic logic [CW-1:0] exp_valid();
    logic [CW-1:0] v = '0;
    for (int k = 0; k < CW; k++) begin
      if (k >= rob_q.size()) break;
      if (!rob_q[k].done) break;
      if (k > 0 && rob_q[k].exc) break;
      v[k] = 1'b1;
      if (rob_q[k].exc) break;
    end
    return v;
  endfunction

  task automatic idle();
    rst_i = 1'b0; disp_valid_i = '0; disp_payload_i = '0;
    wb_en_i = '0; wb_idx_i = '0; wb_exc_i = '0; wb_data_i = '0;
    commit_ack_i = '0; flush_i = 1'b0; flush_idx_i = '0; flush_all_i = 1'b0;
  endtask

  task automatic set_wb(input int p, input int idx, input bit exc);
    wb_en_i[p] = 1'b1;
    wb_idx_i[p*IW +: IW] = IW'(idx);
    wb_exc_i[p] = exc;
    wb_data_i[p*WW +: WW] = rnd_data();
  endtask

  // Record what the DUT must show this cycle, advance the model across the coming edge, wait.
  task automatic step();
    logic [CW-1:0] v;
    int sz, tail, n, pos, keep;
    bit ready;
    ent_t e;
    sz    = rob_q.size();
    tail  = (m_head + sz) % E;
    v     = exp_valid();
    ready = (E - sz) >= DW;
    stat_q.push_back({6'(sz), sz == E, sz == 0, ready, IW'(tail), v});
    if (rst_i || flush_all_i) begin
      rob_q.delete();
      m_head = 0;
    end else begin
      n = 0;
      for (int k = 0; k < CW; k++) if (n == k && v[k] && commit_ack_i[k]) n++;
      for (int k = 0; k < n; k++)
        exp_q.push_back({rob_q[k].idx, rob_q[k].exc, rob_q[k].payload, rob_q[k].data});
      for (int p = 0; p < WP; p++) begin
        if (wb_en_i[p]) begin
          pos = (int'(wb_idx_i[p*IW +: IW]) - m_head + E) % E;
          if (pos < sz) begin
            rob_q[pos].done = 1'b1;
            rob_q[pos].exc  = wb_exc_i[p];
            rob_q[pos].data = wb_data_i[p*WW +: WW];
          end
        end
      end
      if (flush_i) begin
        keep = (int'(flush_idx_i) - m_head + E) % E + 1;
        while (rob_q.size() > keep) void'(rob_q.pop_back());
      end
      for (int k = 0; k < n; k++) void'(rob_q.pop_front());
      m_head = (m_head + n) % E;
      if (!flush_i && ready) begin
        for (int l = 0; l < DW; l++) begin
          if (disp_valid_i[l]) begin
            e.idx = IW'(tail); e.payload = disp_payload_i[l*PW +: PW];
            e.done = 1'b0; e.exc = 1'b0; e.data = '0;
            rob_q.push_back(e);
            tail = (tail + 1) % E;
          end
        end
      end
    end
    @(posedge clk_i); #2;
  endtask

  // Monitor: status every cycle, and every entry the DUT actually retires.
  initial begin
    logic [15:0]   s;
    logic [EW-1:0] got;
    bit            run;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (stat_q.size() == 0) begin
          chk("status_underflow", 256'(1), 256'(0));
        end else begin
          s = stat_q.pop_front();
          chk("status", 256'({count_o, full_o, empty_o, disp_ready_o, assigned_idx_o, commit_valid_o}), 256'(s));
        end
        if (!rst_i && !flush_all_i) begin
          run = 1'b1;
          for (int k = 0; k < CW; k++) begin
            if (run && commit_valid_o[k] && commit_ack_i[k]) begin
              got = {commit_idx_o[k*IW +: IW], commit_exc_o[k], commit_payload_o[k*PW +: PW],
                     commit_data_o[k*WW +: WW]};
              if (exp_q.size() == 0) chk("retire_unexpected", 256'(got), 256'(0));
              else chk("retire_entry", 256'(got), 256'(exp_q.pop_front()));
            end else begin
              run = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    idle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    chk("reset_count", 256'(count_o), 256'(0));
    chk("reset_empty", 256'(empty_o), 256'(1));
    chk("reset_full", 256'(full_o), 256'(0));
    chk("reset_ready", 256'(disp_ready_o), 256'(1));
    chk("reset_assigned", 256'(assigned_idx_o), 256'(0));
    chk("reset_valid", 256'(commit_valid_o), 256'(0));
    mon_en = 1'b1;

    // Ack on an empty buffer.
    commit_ack_i = '1;
    step();

    // Fill with pc 0..31, then one extra request that must be dropped.
    for (int c = 0; c < 16; c++) begin
      idle();
      disp_valid_i = 2'b11;
      disp_payload_i[0 +: PW]  = PW'(2 * c);
      disp_payload_i[PW +: PW] = PW'(2 * c + 1);
      step();
    end
    idle();
    chk("fill_full", 256'(full_o), 256'(1));
    chk("fill_ready", 256'(disp_ready_o), 256'(0));
    disp_valid_i = 2'b01;
    disp_payload_i[0 +: PW] = PW'(32);
    step();
    idle();
    chk("fill_drop_count", 256'(count_o), 256'(32));

    // Out-of-order completion, odd indices first, while acking both lanes.
    for (int c = 0; c < 16; c++) begin
      idle();
      commit_ack_i = 2'b11;
      for (int p = 0; p < 2; p++) begin
        int j;
        j = 2 * c + p;
        set_wb(p, (j < 16) ? (2 * j + 1) : (2 * (j - 16)), 1'b0);
      end
      step();
    end
    idle();
    commit_ack_i = 2'b11;
    repeat (16) step();
    chk("drain_empty", 256'(empty_o), 256'(1));

    // Exception isolation on entry 1.
    idle();
    disp_valid_i = 2'b11; disp_payload_i = {rnd_pl(), rnd_pl()};
    step(); step();
    idle();
    for (int p = 0; p < 4; p++) set_wb(p, p, p == 1);
    step();
    idle();
    commit_ack_i = 2'b11;
    repeat (4) step();

    // Partial flush with same-cycle writeback to a squashed entry and a dispatch.
    idle(); rst_i = 1'b1; step();
    idle();
    disp_valid_i = 2'b11;
    repeat (5) begin disp_payload_i = {rnd_pl(), rnd_pl()}; step(); end
    idle();
    flush_i = 1'b1; flush_idx_i = IW'(4);
    set_wb(0, 7, 1'b0);
    disp_valid_i = 2'b11;
    step();
    idle();
    chk("flush_count", 256'(count_o), 256'(5));
    chk("flush_tail", 256'(assigned_idx_o), 256'(5));
    step();

    // Pointer wrap around the end of the buffer, then a full flush mid-burst.
    idle(); rst_i = 1'b1; step();
    idle();
    disp_valid_i = 2'b11;
    repeat (15) begin disp_payload_i = {rnd_pl(), rnd_pl()}; step(); end
    for (int c = 0; c < 8; c++) begin
      idle();
      for (int p = 0; p < 4; p++) if (4 * c + p < 30) set_wb(p, 4 * c + p, 1'b0);
      step();
    end
    idle();
    commit_ack_i = 2'b11;
    repeat (16) step();
    chk("wrap_tail", 256'(assigned_idx_o), 256'(30));
    idle();
    disp_valid_i = 2'b11;
    repeat (2) begin disp_payload_i = {rnd_pl(), rnd_pl()}; step(); end
    idle();
    set_wb(0, 30, 1'b0); set_wb(1, 31, 1'b0); set_wb(2, 0, 1'b0); set_wb(3, 1, 1'b0);
    step();
    idle();
    commit_ack_i = 2'b11;
    repeat (3) step();
    chk("wrap_empty", 256'(empty_o), 256'(1));
    idle();
    disp_valid_i = 2'b11;
    repeat (3) begin disp_payload_i = {rnd_pl(), rnd_pl()}; step(); end
    flush_all_i = 1'b1; commit_ack_i = 2'b11;
    step();
    idle();
    chk("flush_all_count", 256'(count_o), 256'(0));

    // Random traffic.
    for (int it = 0; it < 3000; it++) begin
      int r;
      idle();
      disp_valid_i = DW'($urandom_range(0, 3));
      disp_payload_i = {rnd_pl(), rnd_pl()};
      for (int p = 0; p < WP; p++) begin
        if ($urandom_range(0, 99) < 40) begin
          if (rob_q.size() > 0 && $urandom_range(0, 99) < 85)
            set_wb(p, int'(rob_q[$urandom_range(0, rob_q.size() - 1)].idx), $urandom_range(0, 15) == 0);
          else
            set_wb(p, $urandom_range(0, E - 1), $urandom_range(0, 15) == 0);
        end
      end
      commit_ack_i = CW'($urandom_range(0, 3));
      r = $urandom_range(0, 199);
      if (r < 4 && rob_q.size() > 2) begin
        flush_i = 1'b1;
        flush_idx_i = rob_q[$urandom_range(2, rob_q.size() - 1)].idx;
      end else if (r == 4) begin
        flush_all_i = 1'b1;
      end else if (r == 5) begin
        rst_i = 1'b1;
      end
      step();
    end
    idle();
    repeat (3) step();
    mon_en = 1'b0;
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
